// File: rtl/sig_serializer.sv
// ---------------------------------------------------------------------------
// sig_serializer
//
// Output stage behind the ECDSA signer. Each 520-bit signature is captured on
// the signer's done strobe into a DEPTH-entry frame buffer. Frames are then
// streamed out as 32-bit words over a valid/ready interface. The buffer
// absorbs host back-pressure so the signer never stalls. Frames that arrive
// while the buffer is full are counted in drop_cnt.
//
// Frame layout (17 words): word k (k = 0..15) = sig_in[519-32k : 488-32k],
// word 16 = {24'h0, sig_in[7:0]}.
//
// Optional feature macro: SIG_SERIALIZER_CHECKSUM_EN
//   When defined, an 18th word carrying the XOR of words 0..16 is appended
//   and out_last moves to that word.
//
// Ports
//   clk        in   1    design clock, rising edge
//   rst        in   1    synchronous active-high reset
//   sig_in     in   520  signature {r[255:0], s[255:0], v[7:0]}
//   sig_valid  in   1    capture strobe (signer done)
//   sig_err    in   1    signer error, sampled with sig_valid
//   out_data   out  32   current output word (registered)
//   out_valid  out  1    out_data valid (registered)
//   out_ready  in   1    consumer accepts the word when high with out_valid
//   out_last   out  1    final word of a frame (registered)
//   full       out  1    all DEPTH entries occupied
//   drop_cnt   out  8    frames dropped on a full buffer, saturating at 255
//   err_flag   out  1    sticky, set when a frame arrives with sig_err high
// ---------------------------------------------------------------------------
module sig_serializer #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [519:0] sig_in,
    input  logic         sig_valid,
    input  logic         sig_err,
    output logic [31:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         full,
    output logic [7:0]   drop_cnt,
    output logic         err_flag
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

`ifdef SIG_SERIALIZER_CHECKSUM_EN
    localparam logic [4:0] LAST_IDX = 5'd17;
`else
    localparam logic [4:0] LAST_IDX = 5'd16;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND
    } state_t;

    logic [519:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [4:0]    r_idx;
    logic [4:0]    w_idx_nxt;
    logic [31:0]   r_out_data;
    logic [31:0]   w_out_data_nxt;
    logic          r_out_valid;
    logic          w_out_valid_nxt;
    logic          r_out_last;
    logic          w_out_last_nxt;
    logic [7:0]    r_drop_cnt;
    logic          r_err_flag;

    logic          w_full;
    logic          w_empty;
    logic          w_hs;
    logic          w_pop;
    logic          w_push_req;
    logic          w_push;
    logic          w_drop;
    logic [519:0]  w_head;

    // Plain frame words 0..16.
    function automatic logic [31:0] word_base(input logic [519:0] f, input logic [4:0] k);
        logic [31:0] w;
        w = {24'h0, f[7:0]};
        for (int i = 0; i < 16; i++) begin
            if (k == 5'(i)) w = f[8 + 32*(15 - i) +: 32];
        end
        return w;
    endfunction

    // Word k of the outgoing frame, including the optional checksum word.
    function automatic logic [31:0] frame_word(input logic [519:0] f, input logic [4:0] k);
`ifdef SIG_SERIALIZER_CHECKSUM_EN
        logic [31:0] w_sum;
        if (k == 5'd17) begin
            w_sum = '0;
            for (int i = 0; i <= 16; i++) w_sum ^= word_base(f, 5'(i));
            return w_sum;
        end
`endif
        return word_base(f, k);
    endfunction

    assign w_full     = (r_count == DEPTH_C);
    assign w_empty    = (r_count == '0);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_hs       = r_out_valid && out_ready;
    assign w_push_req = sig_valid && !sig_err;
    // A pop on the same edge frees the slot the incoming frame needs.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;
        w_out_last_nxt  = r_out_last;
        w_pop           = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_idx_nxt       = '0;
                w_out_data_nxt  = frame_word(w_head, 5'd0);
                w_out_valid_nxt = 1'b1;
                w_out_last_nxt  = 1'b0;
                w_state_nxt     = ST_SEND;
            end
            ST_SEND: begin
                if (w_hs) begin
                    if (r_idx == LAST_IDX) begin
                        w_pop           = 1'b1;
                        w_out_valid_nxt = 1'b0;
                        w_out_last_nxt  = 1'b0;
                        w_state_nxt     = ST_IDLE;
                    end else begin
                        w_idx_nxt      = r_idx + 5'd1;
                        w_out_data_nxt = frame_word(w_head, r_idx + 5'd1);
                        w_out_last_nxt = ((r_idx + 5'd1) == LAST_IDX);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_last  <= w_out_last_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
            r_err_flag <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
            if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
            if (sig_valid && sig_err) r_err_flag <= 1'b1;
        end
    end

    // NOTE: the frame storage has no reset; the pointers and occupancy count
    // define which entries are meaningful, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= sig_in;
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign full      = w_full;
    assign drop_cnt  = r_drop_cnt;
    assign err_flag  = r_err_flag;

endmodule

// File: tb/tb_sig_serializer.sv
// ---------------------------------------------------------------------------
// tb_sig_serializer
//
// Self-checking bench for sig_serializer (DEPTH = 2). A reference model keeps
// the buffered frames in a queue, the position within the frame being sent,
// and a warm-up countdown for the two idle cycles before each frame. Every
// cycle the DUT outputs are compared with the model. Directed scenarios
// cover the listed cases; a randomized phase follows.
// Honours SIG_SERIALIZER_CHECKSUM_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_sig_serializer;

    localparam int DEPTH = 2;
`ifdef SIG_SERIALIZER_CHECKSUM_EN
    localparam int LAST = 17;
`else
    localparam int LAST = 16;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [519:0] sig_in;
    logic         sig_valid;
    logic         sig_err;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         full;
    logic [7:0]   drop_cnt;
    logic         err_flag;

    always #5 clk = ~clk;

    sig_serializer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .sig_valid (sig_valid),
        .sig_err   (sig_err),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .full      (full),
        .drop_cnt  (drop_cnt),
        .err_flag  (err_flag)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic [519:0] mq[$];
    int           widx       = 0;
    int           warm       = 2;
    int           drop_m     = 0;
    bit           err_m      = 1'b0;
    bit           just_reset = 1'b0;

    // Observed DUT traffic, for scenario-level checks.
    int           dut_hs    = 0;
    int           dut_last  = 0;
    logic [31:0]  last_word = '0;

    logic [519:0] f1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    endtask

    function automatic bit exp_valid();
        return (mq.size() > 0) && (warm == 0);
    endfunction

    function automatic logic [31:0] frame_word(input logic [519:0] f, input int k);
        logic [31:0] acc;
        acc = '0;
        if (k < 16) return 32'(f >> (488 - 32*k));
        if (k == 16) return {24'h0, f[7:0]};
        for (int j = 0; j < 16; j++) acc ^= 32'(f >> (488 - 32*j));
        acc ^= {24'h0, f[7:0]};
        return acc;
    endfunction

    function automatic logic [519:0] rand_frame();
        logic [519:0] f;
        f = '0;
        for (int i = 0; i < 17; i++) f = {f[487:0], 32'($urandom())};
        return f;
    endfunction

    // Advance one clock. Called at a falling edge with inputs already driven:
    // updates the model for the coming rising edge, waits for it, then checks
    // the DUT outputs at the next falling edge.
    task automatic tick();
        bit pre_empty;
        bit pop;
        if (!rst && out_valid && out_ready) begin
            dut_hs++;
            if (out_last) begin
                dut_last++;
                last_word = out_data;
            end
        end
        pre_empty = (mq.size() == 0);
        pop = 1'b0;
        if (rst) begin
            mq.delete();
            widx       = 0;
            warm       = 2;
            drop_m     = 0;
            err_m      = 1'b0;
            just_reset = 1'b1;
        end else begin
            just_reset = 1'b0;
            if (exp_valid() && out_ready) begin
                if (widx == LAST) begin
                    pop = 1'b1;
                    void'(mq.pop_front());
                    widx = 0;
                end else begin
                    widx++;
                end
            end
            if (pop || pre_empty) warm = 2;
            else if (warm > 0) warm--;
            if (sig_valid) begin
                if (sig_err) err_m = 1'b1;
                else if (mq.size() < DEPTH) mq.push_back(sig_in);
                else if (drop_m < 255) drop_m++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'(exp_valid()));
        if (exp_valid()) begin
            check("out_data", out_data, frame_word(mq[0], widx));
            check("out_last", 32'(out_last), 32'(widx == LAST));
        end
        if (just_reset) begin
            check("rst_out_data", out_data, 32'h0);
            check("rst_out_last", 32'(out_last), 32'h0);
        end
        check("full", 32'(full), 32'(mq.size() == DEPTH));
        check("drop_cnt", 32'(drop_cnt), 32'(drop_m));
        check("err_flag", 32'(err_flag), 32'(err_m));
    endtask

    task automatic clear_counts();
        dut_hs    = 0;
        dut_last  = 0;
        last_word = '0;
    endtask

    task automatic strobe(input logic [519:0] f);
        sig_in    = f;
        sig_valid = 1'b1;
        sig_err   = 1'b0;
        tick();
        sig_valid = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && mq.size() > 0; i++) tick();
    endtask

    initial begin
        int stall;
        int guard;

        rst       = 1'b1;
        sig_in    = '0;
        sig_valid = 1'b0;
        sig_err   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single frame with the host always ready.
        f1 = {{8{32'h11111111}}, {8{32'h22222222}}, 8'h1B};
        out_ready = 1'b1;
        clear_counts();
        strobe(f1);
        tick();
        check("lat_e1_valid", 32'(out_valid), 32'h0);
        tick();
        check("lat_e2_valid", 32'(out_valid), 32'h1);
        check("first_word", out_data, 32'h11111111);
        drain(40);
        tick();
        check("single_hs", 32'(dut_hs), 32'(LAST + 1));
        check("single_lasts", 32'(dut_last), 32'h1);
        check("single_last_word", last_word, 32'h0000001B);

        // Back-pressure: host stalls three cycles while word 5 is presented.
        clear_counts();
        stall = 0;
        strobe(f1);
        for (int i = 0; i < 60 && mq.size() > 0; i++) begin
            out_ready = !(exp_valid() && widx == 5 && stall < 3);
            if (!out_ready) stall++;
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_hs", 32'(dut_hs), 32'(LAST + 1));
        check("bp_lasts", 32'(dut_last), 32'h1);

        // Overflow: four strobes into a two-entry buffer with the host stalled.
        out_ready = 1'b0;
        sig_err   = 1'b0;
        sig_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sig_in = rand_frame();
            tick();
            if (i == 1) check("ovf_full_after2", 32'(full), 32'h1);
        end
        sig_valid = 1'b0;
        check("ovf_drop", 32'(drop_cnt), 32'h2);
        clear_counts();
        out_ready = 1'b1;
        drain(80);
        tick();
        check("ovf_frames", 32'(dut_last), 32'h2);
        check("ovf_empty_full", 32'(full), 32'h0);

        // Strobe on the same edge as the final-word handshake of a full buffer.
        out_ready = 1'b0;
        strobe(rand_frame());
        strobe(rand_frame());
        check("sim_full_before", 32'(full), 32'h1);
        clear_counts();
        out_ready = 1'b1;
        guard = 0;
        while (!(exp_valid() && widx == LAST) && guard < 40) begin
            tick();
            guard++;
        end
        check("sim_reached_last", 32'(guard < 40), 32'h1);
        strobe(rand_frame());
        check("sim_drop_same", 32'(drop_cnt), 32'h2);
        check("sim_full_after", 32'(full), 32'h1);
        drain(120);
        tick();
        check("sim_frames", 32'(dut_last), 32'h3);

        // Error frame: flag set, nothing buffered or emitted.
        clear_counts();
        sig_in    = rand_frame();
        sig_err   = 1'b1;
        sig_valid = 1'b1;
        tick();
        sig_valid = 1'b0;
        sig_err   = 1'b0;
        check("err_flag_set", 32'(err_flag), 32'h1);
        for (int i = 0; i < 25; i++) tick();
        check("err_no_frame", 32'(dut_hs), 32'h0);

        // Reset while word 9 is on the bus.
        strobe(f1);
        guard = 0;
        while (!(exp_valid() && widx == 9) && guard < 40) begin
            tick();
            guard++;
        end
        check("rst_reached_word9", out_data, 32'h22222222);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data", out_data, 32'h0);
        check("rst_drop", 32'(drop_cnt), 32'h0);
        check("rst_err", 32'(err_flag), 32'h0);
        clear_counts();
        for (int i = 0; i < 40; i++) tick();
        check("rst_no_words", 32'(dut_hs), 32'h0);
        check("rst_no_last", 32'(dut_last), 32'h0);

        // Randomized traffic with back-pressure, error frames and resets.
        for (int i = 0; i < 3000; i++) begin
            sig_in    = rand_frame();
            sig_valid = ($urandom_range(0, 11) == 0);
            sig_err   = ($urandom_range(0, 5) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst       = 1'b0;
        sig_valid = 1'b0;
        sig_err   = 1'b0;
        out_ready = 1'b1;
        drain(200);
        tick();
        check("final_idle", 32'(out_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
